poly_mul_sched: RTL and testbench
=================================

# poly_mul_sched

Round-robin job scheduler in front of the shared NTT/PWM/INTT polynomial core controller. It accepts operation requests from `NREQ` requesters and grants the core to one at a time. For each granted job it issues the `conf`/`start` command sequence, one command per core operation, and returns a per-requester completion or timeout pulse. It sits between client engines (key-gen, encrypt, relinearize) and the core controller's `conf`/`start`/`done` pins.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `IDW`, 2: requester index width, equal to clog2(`NREQ`).
- `TIMEOUT`, 2047: maximum cycles spent in WAIT for one core operation.
- `GAP_CYC`, 2: idle cycles inserted between consecutive core operations of one job (≥1).
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in `NREQ`: per-requester request level.
- `req_op` in 2*`NREQ`: op code, requester r at bits [2r+1:2r]. Codes: 00 = full multiply (NTT→PWM→INTT), 01 = NTT, 10 = PWM, 11 = INTT.
- `core_done` in 1: one-cycle done pulse from the core controller.
- `core_conf` out 3: 1 = NTT, 2 = PWM, 3 = INTT, 0 = none.
- `core_start` out 1: one-cycle start pulse to the core.
- `gnt` out `NREQ`: one-hot grant, held for the whole job.
- `gnt_id` out `IDW`: index of the granted requester, used by the data-bank muxes.
- `step` out 2: index of the current operation within the job (0..2).
- `busy` out 1: high whenever state ≠ IDLE.
- `job_done` out `NREQ`: one-cycle completion pulse to the owning requester.
- `job_err` out `NREQ`: one-cycle timeout pulse to the owning requester.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- **IDLE**
  - If any `req` is high, pick the first requester at or after `ptr+1` (modulo `NREQ`).
  - Latch its op; set `n_steps` = 3 for code 00, otherwise 1.
  - Set `gnt`/`gnt_id`, set `step`=0, go to ISSUE.
- **ISSUE** (one cycle)
  - `core_start`=1; `core_conf` = op of the current step. For the full-multiply sequence the confs are 1, 2, 3 in order.
  - Clear the watchdog; go to WAIT.
- **WAIT**
  - `core_conf` is held; the watchdog increments every cycle.
  - On `core_done` with `step` < `n_steps`-1: `step`++, go to GAP.
  - On `core_done` with the last step: pulse `job_done[gnt_id]`, clear `gnt`, set `ptr`=`gnt_id`, go to IDLE.
  - When the watchdog reaches `TIMEOUT` without `core_done`: pulse `job_err[gnt_id]`, clear `gnt`, set `ptr`=`gnt_id`, go to IDLE. The remaining steps are abandoned.
  - If `core_done` and the timeout occur in the same cycle, `core_done` wins.
- **GAP**
  - `core_conf`=0; count `GAP_CYC` cycles, then go to ISSUE. This lets the core controller return to its idle state.
- `core_done` is ignored in IDLE, ISSUE and GAP.
- `req` and `req_op` are sampled only in IDLE. A deasserted `req` during a job has no effect; the job always runs to done or error.
- A requester whose `req` is still high after its `job_done` is re-arbitrated at lowest priority.
- `ptr` is `IDW` bits wide and wraps at `NREQ`-1 → 0.
- All outputs are registered except `core_start`, which is decoded from state ISSUE.
- The watchdog is 11 bits and saturates; it never wraps.

## Timing
- Reset values: state IDLE, `ptr`=`NREQ`-1 (requester 0 wins first), all other outputs and counters 0.
- Reset asserted mid-job: on the next edge `gnt`, `core_start`, `job_done` and `job_err` go to 0 and state goes to IDLE. No completion pulse is produced.
- Request to start:
  - `req` sampled high at edge t.
  - `gnt`, `gnt_id` and `core_conf` are valid from t+1, and `core_start` is high during cycle t+1.
- Done to next step: `core_done` in cycle d → GAP over d+1..d+`GAP_CYC` → next `core_start` in cycle d+`GAP_CYC`+1.
- Done to job end:
  - Last `core_done` in cycle d → `job_done` high and `gnt` low in cycle d+1.
  - The earliest next `gnt` is in cycle d+2.
- Timeout:
  - `job_err` fires `TIMEOUT`+1 cycles after the `core_start` cycle if `core_done` never arrives.
  - `gnt` drops in the same cycle as `job_err`.
- Overhead of a full multiply beyond core time: 1 + 2·(`GAP_CYC`+1) + 1 cycles.

## Test plan
- **Reset values:** hold `rst` 3 cycles → all outputs 0, `busy`=0. Then `req`=0001 with op 01 → `gnt`=0001 and `core_start` one cycle after the request edge.
- **Full multiply:** `req[2]` with op 00 and a core model returning done 20 cycles after start → `core_conf` sequence 1, 2, 3 with exactly 3 `core_start` pulses spaced 20+`GAP_CYC`+1 cycles apart; `job_done`=0100 one cycle after the third done; `step` goes 0→1→2.
- **Round-robin:** `req`=1111, all op 10, held continuously → grant order 0, 1, 2, 3, 0; never two grants in one cycle; `job_done` always matches the granted index.
- **Timeout:** core model never returns done → `job_err[gnt_id]` exactly `TIMEOUT`+1 cycles after `core_start`, `job_done` stays 0, then the next requester is granted.
- **Done/timeout race and spurious done:** `core_done` in the same cycle the watchdog hits `TIMEOUT` → `job_done` asserted, `job_err` not. `core_done` in IDLE or GAP → no state change.
- **Mid-job reset and mid-job request drop:**
  - `rst` during WAIT → IDLE next edge, `gnt`=0, no pulses; a fresh request after reset grants requester 0 first.
  - `req` dropped mid-job → the job completes normally.

Source files
------------

// File: rtl/poly_mul_sched_if.sv
// poly_mul_sched_if: bundles the requester-side and core-side signals of the
// polynomial-core job scheduler.
//   master : the scheduler (drives grants, completion pulses and core commands)
//   slave  : clients plus core controller (drive requests, op codes and core_done)
// Signals:
//   req        - per-requester request level
//   req_op     - 2-bit op code per requester, requester r at [2r+1:2r]
//   core_done  - one-cycle done pulse from the core controller
//   core_conf  - operation selector for the core (1 NTT, 2 PWM, 3 INTT, 0 none)
//   core_start - one-cycle start pulse to the core
//   gnt        - one-hot grant, held for the whole job
//   gnt_id     - index of the granted requester
//   step       - index of the current operation within the job
//   busy       - scheduler not idle
//   job_done   - one-cycle completion pulse to the owning requester
//   job_err    - one-cycle timeout pulse to the owning requester
interface poly_mul_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_op;
  logic              core_done;
  logic [2:0]        core_conf;
  logic              core_start;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_id;
  logic [1:0]        step;
  logic              busy;
  logic [NREQ-1:0]   job_done;
  logic [NREQ-1:0]   job_err;

  modport master (
    input  req, req_op, core_done,
    output core_conf, core_start, gnt, gnt_id, step, busy, job_done, job_err
  );

  modport slave (
    output req, req_op, core_done,
    input  core_conf, core_start, gnt, gnt_id, step, busy, job_done, job_err
  );
endinterface

// File: rtl/poly_mul_sched.sv
// poly_mul_sched: round-robin job scheduler in front of the shared NTT/PWM/INTT
// core controller. Grants the core to one requester at a time, issues one
// conf/start command per core operation of the job, and returns a completion
// or timeout pulse to the owner.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   bus_io - scheduler side of poly_mul_sched_if (requests, grants, core commands)
// Parameters:
//   NREQ    - number of requesters (2..8)
//   IDW     - requester index width, clog2(NREQ)
//   TIMEOUT - max cycles spent waiting for one core operation (1..2047)
//   GAP_CYC - idle cycles between consecutive operations of one job (>= 1)
module poly_mul_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 2047,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  poly_mul_sched_if.master bus_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  localparam int unsigned     GapW    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYC - 1);
  // The watchdog counts from 0 in the first WAIT cycle, so TIMEOUT waiting
  // cycles have elapsed when it holds TIMEOUT-1.
  localparam logic [10:0]     WdLast  = 11'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [1:0]        op_q, op_d;
  logic [1:0]        step_q, step_d;
  logic [10:0]       wd_q, wd_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0]    gnt_id_q, gnt_id_d;
  logic [2:0]        conf_q, conf_d;
  logic              busy_q, busy_d;
  logic [NREQ-1:0]   job_done_q, job_done_d;
  logic [NREQ-1:0]   job_err_q, job_err_d;

  logic              arb_found;
  logic [IDW-1:0]    arb_idx;
  logic [IDW-1:0]    arb_cand;
  logic [1:0]        arb_op;
  logic              is_last;

  // Op code 00 expands to NTT, PWM, INTT over steps 0..2; the others are single ops.
  function automatic logic [2:0] conf_of(input logic [1:0] op, input logic [1:0] stp);
    if (op == 2'b00) begin
      return {1'b0, stp} + 3'd1;
    end
    return {1'b0, op};
  endfunction

  // Round-robin pick: first active request at or after ptr+1, wrapping at NREQ.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_cand  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      arb_cand = IDW'((ptr_q + i) % NREQ);
      if (!arb_found && bus_io.req[arb_cand]) begin
        arb_found = 1'b1;
        arb_idx   = arb_cand;
      end
    end
    arb_op = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (arb_idx == IDW'(r)) begin
        arb_op = bus_io.req_op[2*r +: 2];
      end
    end
  end

  assign is_last = (op_q == 2'b00) ? (step_q == 2'd2) : 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    op_d       = op_q;
    step_d     = step_q;
    wd_d       = wd_q;
    gap_d      = gap_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    conf_d     = conf_q;
    job_done_d = '0;
    job_err_d  = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d  = StIssue;
          gnt_d    = NREQ'(1) << arb_idx;
          gnt_id_d = arb_idx;
          op_d     = arb_op;
          step_d   = 2'd0;
          conf_d   = conf_of(arb_op, 2'd0);
        end
      end
      StIssue: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // core_done is tested first so it wins a same-cycle timeout.
        if (bus_io.core_done) begin
          if (is_last) begin
            job_done_d = gnt_q;
            gnt_d      = '0;
            ptr_d      = gnt_id_q;
            step_d     = 2'd0;
            state_d    = StIdle;
          end else begin
            step_d  = step_q + 2'd1;
            gap_d   = '0;
            conf_d  = 3'd0;
            state_d = StGap;
          end
        end else if (wd_q >= WdLast) begin
          job_err_d = gnt_q;
          gnt_d     = '0;
          ptr_d     = gnt_id_q;
          step_d    = 2'd0;
          state_d   = StIdle;
        end else if (wd_q != '1) begin
          wd_d = wd_q + 11'd1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          conf_d  = conf_of(op_q, step_q);
          state_d = StIssue;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= IDW'(NREQ - 1);
      op_q       <= '0;
      step_q     <= '0;
      wd_q       <= '0;
      gap_q      <= '0;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      conf_q     <= '0;
      busy_q     <= 1'b0;
      job_done_q <= '0;
      job_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      op_q       <= op_d;
      step_q     <= step_d;
      wd_q       <= wd_d;
      gap_q      <= gap_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      conf_q     <= conf_d;
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
      job_err_q  <= job_err_d;
    end
  end

  assign bus_io.core_start = (state_q == StIssue);
  assign bus_io.core_conf  = conf_q;
  assign bus_io.gnt        = gnt_q;
  assign bus_io.gnt_id     = gnt_id_q;
  assign bus_io.step       = step_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.job_done   = job_done_q;
  assign bus_io.job_err    = job_err_q;

endmodule

// File: tb/tb_poly_mul_sched.sv
// Self-checking bench for poly_mul_sched: reset checks, a table of single jobs,
// hand-written corner sequences, and a randomized run against a job-timeline model.
module tb_poly_mul_sched;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDW     = 2;
  localparam int unsigned TIMEOUT = 2047;
  localparam int unsigned GAP_CYC = 2;

  localparam logic [2:0][2:0] CFull = {3'd3, 3'd2, 3'd1};
  localparam logic [2:0][2:0] CNtt  = {3'd0, 3'd0, 3'd1};
  localparam logic [2:0][2:0] CPwm  = {3'd0, 3'd0, 3'd2};
  localparam logic [2:0][2:0] CIntt = {3'd0, 3'd0, 3'd3};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_mul_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  poly_mul_sched #(
    .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] s_gnt, s_done, s_err;
  logic [1:0] s_gid, s_step;
  logic [2:0] s_conf;
  logic       s_start, s_busy;

  int core_lat = 0;  // 0: core never answers
  int core_cnt = 0;
  bit spur_gap = 1'b0;

  typedef struct {
    logic [3:0]      req;
    logic [7:0]      op;
    int              lat;
    int              exp_w;
    int              n;
    logic [2:0][2:0] confs;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Advance to the next falling edge, sample outputs, run the core model.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_gnt   = bus.gnt;
    s_gid   = bus.gnt_id;
    s_conf  = bus.core_conf;
    s_start = bus.core_start;
    s_step  = bus.step;
    s_busy  = bus.busy;
    s_done  = bus.job_done;
    s_err   = bus.job_err;
    bus.core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) bus.core_done = 1'b1;
    end
    if (s_start && core_lat > 0) core_cnt = core_lat;
    if (spur_gap && s_busy && !s_start && s_conf == 3'd0) bus.core_done = 1'b1;
    if (rst) core_cnt = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.req_op = '0;
    core_lat = 0;
    spur_gap = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  // Caller has just driven the request for the current cycle. Checks the whole job
  // against the timeline: start k at s0 + k*(lat+GAP_CYC+1), end one cycle after the
  // last done, or TIMEOUT+1 cycles after the start on timeout.
  task automatic run_one(input string name, input int exp_w, input int n,
                         input logic [2:0][2:0] confs, input int lat, input bit tmo,
                         input bit keep_req, input bit drop_req);
    int s0, e;
    int st[3];
    bit is_start;
    logic [3:0] oh;
    s0 = cyc + 1;
    core_lat = tmo ? 0 : lat;
    for (int k = 0; k < 3; k++) st[k] = s0 + k * (lat + int'(GAP_CYC) + 1);
    e = tmo ? s0 + int'(TIMEOUT) + 1 : st[n-1] + lat + 1;
    oh = 4'b0001 << exp_w;
    while (cyc < e) begin
      tick();
      chk({name, ".gnt"}, 32'(s_gnt), (cyc < e) ? 32'(oh) : 32'd0);
      is_start = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (cyc == st[k] && (!tmo || k == 0)) begin
          is_start = 1'b1;
          chk({name, ".conf"}, 32'(s_conf), 32'(confs[k]));
          chk({name, ".step"}, 32'(s_step), k);
          chk({name, ".gnt_id"}, 32'(s_gid), exp_w);
        end
      end
      chk({name, ".start"}, 32'(s_start), 32'(is_start));
      chk({name, ".job_done"}, 32'(s_done), (cyc == e && !tmo) ? 32'(oh) : 32'd0);
      chk({name, ".job_err"}, 32'(s_err), (cyc == e && tmo) ? 32'(oh) : 32'd0);
      if (drop_req && cyc == s0) bus.req = '0;
    end
    if (!keep_req) bus.req = '0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int w, jg, jend, jlat, jnst, lim;
    int js[3];
    logic [2:0] jconf[3];
    logic [1:0] jop;
    bit jtmo, jvalid, in_wait, st_now;
    int mptr, pick;
    logic [3:0] eoh;

    bus.req = '0;
    bus.req_op = '0;
    bus.core_done = 1'b0;

    vecs[0] = '{4'b0001, 8'h01,        5,  0, 1, CNtt};
    vecs[1] = '{4'b0001, 8'h00,        3,  0, 3, CFull};
    vecs[2] = '{4'b0011, 8'b0000_1110, 4,  1, 1, CIntt};
    vecs[3] = '{4'b1001, 8'h01,        4,  3, 3, CFull};
    vecs[4] = '{4'b1010, 8'b0100_1000, 2,  1, 1, CPwm};
    vecs[5] = '{4'b1100, 8'b1011_0000, 7,  2, 1, CIntt};
    vecs[6] = '{4'b1101, 8'b1101_0000, 1,  3, 1, CIntt};
    vecs[7] = '{4'b0100, 8'h00,        2,  2, 3, CFull};
    vecs[8] = '{4'b0100, 8'h00,        20, 2, 3, CFull};

    // Reset values, then the first request.
    apply_reset();
    chk("rst.gnt", 32'(s_gnt), 0);
    chk("rst.gnt_id", 32'(s_gid), 0);
    chk("rst.conf", 32'(s_conf), 0);
    chk("rst.start", 32'(s_start), 0);
    chk("rst.step", 32'(s_step), 0);
    chk("rst.busy", 32'(s_busy), 0);
    chk("rst.job_done", 32'(s_done), 0);
    chk("rst.job_err", 32'(s_err), 0);
    tick();
    bus.req = 4'b0001;
    bus.req_op = 8'h01;
    run_one("first", 0, 1, CNtt, 4, 1'b0, 1'b0, 1'b0);

    // Table of single jobs from a fresh reset (pointer starts at NREQ-1).
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.req = vecs[i].req;
      bus.req_op = vecs[i].op;
      run_one($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].n, vecs[i].confs, vecs[i].lat,
              1'b0, 1'b0, 1'b0);
    end

    // Round-robin with all requests held.
    apply_reset();
    tick();
    bus.req = 4'b1111;
    bus.req_op = 8'hAA;
    for (int j = 0; j < 5; j++) begin
      run_one($sformatf("rr%0d", j), j % 4, 1, CPwm, 3, 1'b0, (j < 4), 1'b0);
    end

    // Timeout on requester 1, then requester 2 is served.
    tick();
    bus.req = 4'b0110;
    bus.req_op = 8'h24;
    run_one("tmo", 1, 1, CNtt, 0, 1'b1, 1'b1, 1'b0);
    run_one("tmo_next", 2, 1, CPwm, 5, 1'b0, 1'b0, 1'b0);

    // Done arriving exactly when the watchdog expires.
    tick();
    bus.req = 4'b1000;
    bus.req_op = 8'h40;
    run_one("race", 3, 1, CNtt, TIMEOUT, 1'b0, 1'b0, 1'b0);

    // Spurious done while idle, then during the gaps of a full multiply.
    for (int j = 0; j < 4; j++) begin
      tick();
      if (j > 0) begin
        chk("spur_idle.busy", 32'(s_busy), 0);
        chk("spur_idle.gnt", 32'(s_gnt), 0);
        chk("spur_idle.start", 32'(s_start), 0);
        chk("spur_idle.job_done", 32'(s_done), 0);
      end
      bus.core_done = 1'b1;
    end
    tick();
    bus.req = 4'b0001;
    bus.req_op = 8'h00;
    spur_gap = 1'b1;
    run_one("spur_gap", 0, 3, CFull, 4, 1'b0, 1'b0, 1'b0);
    spur_gap = 1'b0;

    // Reset in the middle of a job.
    tick();
    bus.req = 4'b0100;
    bus.req_op = 8'h00;
    core_lat = 10;
    repeat (6) tick();
    rst = 1'b1;
    bus.req = '0;
    tick();
    chk("midrst.gnt", 32'(s_gnt), 0);
    chk("midrst.busy", 32'(s_busy), 0);
    chk("midrst.start", 32'(s_start), 0);
    chk("midrst.job_done", 32'(s_done), 0);
    chk("midrst.job_err", 32'(s_err), 0);
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("postrst.busy", 32'(s_busy), 0);
      chk("postrst.pulses", 32'({s_done, s_err}), 0);
    end
    bus.req = 4'b1111;
    bus.req_op = 8'hAA;
    run_one("postrst", 0, 1, CPwm, 2, 1'b0, 1'b0, 1'b0);

    // Request dropped right after the start: the job still completes.
    tick();
    bus.req = 4'b1000;
    bus.req_op = 8'h40;
    run_one("drop", 3, 1, CNtt, 6, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against a job-timeline model.
    apply_reset();
    mptr = NREQ - 1;
    jvalid = 1'b0;
    jend = 0;
    jg = 0;
    w = 0;
    jlat = 1;
    jnst = 1;
    jtmo = 1'b0;
    for (int k = 0; k < 3; k++) begin
      js[k] = 0;
      jconf[k] = 3'd0;
    end
    for (int it = 0; it < 8000; it++) begin
      tick();
      eoh = 4'b0001 << w;
      st_now = 1'b0;
      for (int k = 0; k < jnst; k++) begin
        if (jvalid && cyc == js[k]) begin
          st_now = 1'b1;
          chk("rnd.conf", 32'(s_conf), 32'(jconf[k]));
          chk("rnd.step", 32'(s_step), k);
          chk("rnd.gnt_id", 32'(s_gid), w);
        end
      end
      chk("rnd.gnt", 32'(s_gnt), (jvalid && cyc >= jg && cyc < jend) ? 32'(eoh) : 32'd0);
      chk("rnd.busy", 32'(s_busy), (jvalid && cyc >= jg && cyc < jend) ? 32'd1 : 32'd0);
      chk("rnd.start", 32'(s_start), 32'(st_now));
      chk("rnd.job_done", 32'(s_done), (jvalid && cyc == jend && !jtmo) ? 32'(eoh) : 32'd0);
      chk("rnd.job_err", 32'(s_err), (jvalid && cyc == jend && jtmo) ? 32'(eoh) : 32'd0);

      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 5) == 0) begin
          bus.req[r] = ~bus.req[r];
          if (bus.req[r]) bus.req_op[2*r +: 2] = 2'($urandom_range(0, 3));
        end
      end

      in_wait = 1'b0;
      lim = jtmo ? int'(TIMEOUT) : jlat;
      for (int k = 0; k < jnst; k++) begin
        if (jvalid && cyc >= js[k] + 1 && cyc <= js[k] + lim) in_wait = 1'b1;
      end
      if (!in_wait && $urandom_range(0, 9) == 0) bus.core_done = 1'b1;

      if (cyc >= jend && bus.req != '0) begin
        for (int i = NREQ; i >= 1; i--) begin
          if (bus.req[(mptr + i) % NREQ]) w = (mptr + i) % NREQ;
        end
        jop = bus.req_op[2*w +: 2];
        pick = int'($urandom_range(0, 63));
        jtmo = (pick == 0);
        jlat = (pick == 1) ? int'(TIMEOUT) : int'($urandom_range(1, 12));
        jnst = jtmo ? 1 : ((jop == 2'b00) ? 3 : 1);
        jg = cyc + 1;
        for (int k = 0; k < 3; k++) begin
          js[k] = jg + k * (jlat + int'(GAP_CYC) + 1);
          jconf[k] = (jop == 2'b00) ? 3'(k + 1) : {1'b0, jop};
        end
        jend = jtmo ? jg + int'(TIMEOUT) + 1 : js[jnst-1] + jlat + 1;
        core_lat = jtmo ? 0 : jlat;
        mptr = w;
        jvalid = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
